// File: rtl/i2s_pkg.sv
// Shared I2S constants and the receive-side state encoding.
package i2s_pkg;
  localparam int DATA_WIDTH = 24;
  localparam int SLOT_WIDTH = 32;

  typedef enum logic [1:0] {S_SYNC, S_SHIFT, S_PAD} rx_state_t;
endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser for one slow input, plus a history flop for rise detect.
module i2s_edge_sync (
  input  logic mclk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic meta, lvl, prev;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      lvl  <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      lvl  <= meta;
      prev <= lvl;
    end
  end

  assign q    = lvl;
  assign rise = lvl & ~prev;
endmodule

// File: rtl/i2s_receiver.sv
// Standard-I2S capture: serial ADC stream to parallel left/right words with a
// pair-complete strobe and a short-word error strobe.
module i2s_receiver #(
  parameter int DATA_WIDTH = i2s_pkg::DATA_WIDTH,
  parameter int SLOT_WIDTH = i2s_pkg::SLOT_WIDTH
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  valid,
  output logic                  frame_err
);
  import i2s_pkg::*;

  localparam int CW      = $clog2(SLOT_WIDTH) + 1;
  localparam int NUM_SIG = 3;
  localparam int SIG_SCLK = 0, SIG_LR = 1, SIG_SD = 2;

  logic [NUM_SIG-1:0] raw_v, sync_v, rise_v;
  assign raw_v = {sdin, lrclk, sclk};

  // Identical synchronisers keep sclk/lrclk/sdin mutually aligned.
  for (genvar i = 0; i < NUM_SIG; i++) begin : gen_sync
    i2s_edge_sync u_sync (
      .mclk (mclk),
      .rst  (rst),
      .d    (raw_v[i]),
      .q    (sync_v[i]),
      .rise (rise_v[i])
    );
  end

  logic sclk_rise, lr_s, sd_s;
  assign sclk_rise = |(rise_v & (NUM_SIG'(1) << SIG_SCLK));
  assign lr_s      = |(sync_v & (NUM_SIG'(1) << SIG_LR));
  assign sd_s      = |(sync_v & (NUM_SIG'(1) << SIG_SD));

  rx_state_t             state, state_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  chan, chan_n;
  logic                  lr_prev, primed, left_pend;
  logic                  boundary, wr_left, wr_right, err_n;

  // lr_prev is meaningless until one rise has been seen after reset; without
  // the primed flag a reset released mid-right-slot would fake a boundary.
  assign boundary = primed & (lr_s != lr_prev);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= S_SYNC;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    chan_n    = chan;
    shreg_n   = shreg;
    wr_left   = 1'b0;
    wr_right  = 1'b0;
    err_n     = 1'b0;
    if (sclk_rise) begin
      case (state)
        S_SYNC, S_PAD: begin
          if (state == S_PAD && bit_cnt != '1) bit_cnt_n = bit_cnt + 1'b1;
          if (boundary) begin
            state_n   = S_SHIFT;
            bit_cnt_n = '0;
            chan_n    = lr_s;
          end
        end
        S_SHIFT: begin
          if (boundary) begin
            err_n     = 1'b1;
            bit_cnt_n = '0;
            chan_n    = lr_s;
          end else begin
            shreg_n   = {shreg[DATA_WIDTH-2:0], sd_s};
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              wr_left  = ~chan;
              wr_right = chan;
              state_n  = S_PAD;
            end
          end
        end
        default: state_n = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      chan       <= 1'b0;
      lr_prev    <= 1'b0;
      primed     <= 1'b0;
      left_pend  <= 1'b0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      chan      <= chan_n;
      valid     <= wr_right & left_pend;
      frame_err <= err_n;
      if (sclk_rise) begin
        lr_prev <= lr_s;
        primed  <= 1'b1;
      end
      if (wr_left)  left_data  <= shreg_n;
      if (wr_right) right_data <= shreg_n;
      if (wr_left)       left_pend <= 1'b1;
      else if (wr_right) left_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// Slot-level I2S stimulus against a word/pair scoreboard model.
module tb_i2s_receiver;
  localparam int DW   = 24;
  localparam int SLOT = 32;

  logic          mclk = 1'b0;
  logic          rst, sclk, lrclk, sdin;
  logic [DW-1:0] left_data, right_data;
  logic          valid, frame_err;

  i2s_receiver #(.DATA_WIDTH(DW), .SLOT_WIDTH(SLOT)) dut (
    .mclk       (mclk),
    .rst        (rst),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sdin       (sdin),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  always #5 mclk = ~mclk;

  int            checks = 0, failures = 0;
  int            err_exp = 0, err_seen = 0;
  logic [DW-1:0] ml = '0, mr = '0;
  bit            pend = 0, synced = 0;
  logic          cur_ch = 1'b1;
  logic [2*DW-1:0] obs_q[$];

  task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed strobes, collected away from the active edge.
  always @(negedge mclk) begin
    if (!rst) begin
      if (valid)     obs_q.push_back({left_data, right_data});
      if (frame_err) err_seen++;
    end
  end

  // One I2S slot on the next channel: delay bit, nb data bits MSB first, then
  // padding up to SLOT when the word is complete. rst_at >= 0 pulses reset.
  task automatic slot(input logic [DW-1:0] w, input int nb, input int rst_at, input int pad_mode);
    logic ch, b, cap, pair;
    logic [2*DW-1:0] o;
    int len;
    ch = ~cur_ch;
    cur_ch = ch;
    cap = synced;
    pair = 0;
    len = (nb == DW) ? SLOT : nb + 1;
    for (int i = 0; i < len; i++) begin
      @(negedge mclk);
      if (i >= 1 && i <= nb) b = w[DW-i];
      else b = (pad_mode == 0) ? 1'b0 : (pad_mode == 1) ? 1'b1 : 1'($urandom);
      sclk = 1'b0; lrclk = ch; sdin = b;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_left",  2*DW'(left_data),  '0);
        chk("rst_right", 2*DW'(right_data), '0);
        chk("rst_valid", 2*DW'(valid),      '0);
        cap = 0; ml = '0; mr = '0; pend = 0;
        @(negedge mclk);
        rst = 1'b0;
        repeat (3) @(negedge mclk);
      end else begin
        repeat (4) @(negedge mclk);
      end
      sclk = 1'b1;
      repeat (3) @(negedge mclk);
    end
    // A short word is reported at the next boundary, i.e. during this slot.
    chk("ferr_cnt", 2*DW'(err_seen), 2*DW'(err_exp));
    if (cap) begin
      if (nb == DW) begin
        if (!ch) begin ml = w; pend = 1; end
        else begin mr = w; pair = pend; pend = 0; end
      end else err_exp++;
    end
    if (pair) begin
      if (obs_q.size() == 0) chk("valid_missing", '0, 1);
      else begin
        o = obs_q.pop_front();
        chk("pair", o, {ml, mr});
      end
    end
    chk("valid_extra", 2*DW'(obs_q.size()), '0);
    chk("left_data",  2*DW'(left_data),  2*DW'(ml));
    chk("right_data", 2*DW'(right_data), 2*DW'(mr));
    synced = 1;
  endtask

  logic [DW-1:0] sweep[7];

  initial begin
    #1_500_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    sweep = '{24'd50321, 24'd2131, 24'd34245, 24'd12312, 24'd9044432, 24'd0, 24'd16777215};
    rst = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    repeat (5) @(negedge mclk);
    chk("reset_left",  2*DW'(left_data),  '0);
    chk("reset_right", 2*DW'(right_data), '0);
    chk("reset_valid", 2*DW'(valid),      '0);
    chk("reset_ferr",  2*DW'(frame_err),  '0);
    rst = 1'b0;
    repeat (3) @(negedge mclk);

    // Nominal stream; the first slot after reset is never captured.
    repeat (3) begin
      slot(24'd50321, DW, -1, 0);
      slot(24'hFFFFFF, DW, -1, 0);
    end
    // Reset released mid-right-slot.
    slot(24'd50321, DW, -1, 0);
    slot(24'hFFFFFF, DW, 10, 0);
    slot(24'h123456, DW, -1, 2);
    slot(24'h654321, DW, -1, 2);
    slot(24'h0F0F0F, DW, -1, 2);
    slot(24'hF0F0F0, DW, -1, 2);
    // Padding all ones must not leak into the words.
    repeat (2) begin
      slot(24'd9044432, DW, -1, 1);
      slot(24'd0, DW, -1, 1);
    end
    // Left word cut short after 10 bits.
    slot(24'hABCDEF, 10, -1, 0);
    slot(24'h111111, DW, -1, 0);
    slot(24'h222222, DW, -1, 0);
    slot(24'h333333, DW, -1, 0);
    // Reset pulse mid left word.
    slot(24'h444444, DW, 15, 2);
    slot(24'h555555, DW, -1, 2);
    slot(24'h666666, DW, -1, 2);
    slot(24'h777777, DW, -1, 2);
    // Word sweep alternating L/R.
    for (int k = 0; k < 7; k++) slot(sweep[k], DW, -1, 2);
    slot(24'($urandom), DW, -1, 2);
    // Random words, random padding, occasional short words.
    for (int k = 0; k < 14; k++)
      slot(24'($urandom), ($urandom_range(0, 5) == 0) ? $urandom_range(2, 23) : DW, -1, 2);
    slot(24'($urandom), DW, -1, 2);
    slot(24'($urandom), DW, -1, 2);
    slot(24'($urandom), DW, -1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Deserialises a standard-I2S serial stream from the ADC into parallel 24-bit left/right samples for the effects pipeline; it is the capture-side counterpart to `i2s_transmitter`. Bit and word clocks come from `i2s_clock_divider` and are treated as slow data inputs sampled on `mclk`, so the whole block runs in a single clock domain. A completed stereo frame is presented with a one-cycle `valid` strobe.

## Interface
- `DATA_WIDTH`, 24: audio word width, MSB first.
- `SLOT_WIDTH`, 32: `sclk` periods per `lrclk` half-period; must be at least `DATA_WIDTH` + 1.

- `mclk`  in  1: system/master clock; all flops on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sclk`  in  1: I2S bit clock (`mclk`/8), sampled as data.
- `lrclk`  in  1: I2S word select; 0 = left, 1 = right.
- `sdin`  in  1: serial data from the ADC, changes on `sclk` falling edge.
- `left_data`  out  DATA_WIDTH: last completed left word.
- `right_data`  out  DATA_WIDTH: last completed right word.
- `valid`  out  1: one-`mclk` pulse when a left+right pair has been updated.
- `frame_err`  out  1: one-`mclk` pulse when a word is cut short.

## Operation
- `sclk`, `lrclk` and `sdin` each pass through an identical two-flop synchroniser, preserving their mutual alignment. A third flop on `sclk` gives rising-edge detect `sclk_rise`.
- All bit-level actions occur only on `mclk` cycles where `sclk_rise` = 1.
- At each `sclk_rise`, register `lr_prev` holds `lrclk` from the previous rise. A word boundary is `lrclk` != `lr_prev`.
- FSM states:
  - S_SYNC (reset state): ignore data. On a boundary go to S_SHIFT with `bit_cnt` = 0 and `chan` = `lrclk`. The boundary bit is the I2S one-bit delay and is discarded.
  - S_SHIFT: on each rise, `shreg` = {`shreg`[DATA_WIDTH-2:0], `sdin`} and `bit_cnt`++. When `bit_cnt` reaches DATA_WIDTH, store `shreg` (including this bit) into `left_data` if `chan` = 0, else into `right_data`, then go to S_PAD.
  - S_PAD: ignore `sdin` until a boundary, then restart as from S_SYNC.
- Boundary in S_SHIFT before DATA_WIDTH bits are captured:
  - pulse `frame_err`;
  - discard the partial word and leave the output register unchanged;
  - restart S_SHIFT for the new channel with `bit_cnt` = 0.
- `valid` pulses when `right_data` is written, but only if `left_data` was written since the previous `valid`, i.e. a left-then-right pair. A right word with no preceding left (first frame after reset, or a left error) updates `right_data` without `valid`.
- `bit_cnt` is $clog2(SLOT_WIDTH)+1 bits wide. It saturates in S_PAD and never wraps.
- Reset, asynchronous at any point including mid-word:
  - all outputs, `shreg`, `bit_cnt` and the synchronisers go to 0;
  - FSM goes to S_SYNC and the pending-left flag is cleared.

## Timing
- Input-to-decision latency: 3 `mclk` cycles from an external `sclk` rise to the cycle `sclk_rise` is seen.
- Word register and `valid` update on the `mclk` edge after the `sclk_rise` cycle of the last data bit, i.e. ~4 `mclk` after the physical `sclk` edge.
- `valid` and `frame_err` are exactly 1 `mclk` wide.
- `left_data` and `right_data` are stable between writes; downstream may sample them any cycle after `valid`.
- At the default ratio (512 `mclk`/frame), the right word completes 25 `sclk` (200 `mclk`) after the `lrclk` rise.

## Structure
- Shared `i2s_pkg`: `DATA_WIDTH`/`SLOT_WIDTH` default constants and the `rx_state_t` enum {S_SYNC, S_SHIFT, S_PAD}, reused by the transmitter and later stages.
- Sub-module `i2s_edge_sync`: per-signal two-flop synchroniser plus previous-value flop. It outputs the synchronised level and the rise pulse, with the same async `rst`.
- Top holds the FSM, shift register, counter and output registers.

## Test plan
- `i2s_clock_divider` drives `sclk`/`lrclk`, and an ADC model sends left = 50321 (0x00C491), right = 16777215 (0xFFFFFF) → after the first complete left+right pair, `valid` pulses once with `left_data` = 50321 and `right_data` = 16777215, then once per frame.
- Reset released mid-right-slot → no `valid` and no write until the next full left+right pair; the first `valid` carries the correct pair.
- Frames with left = 9044432 (0x8A01D0), right = 0, padding bits all 1 → outputs exactly 9044432 and 0, proving pad bits are ignored.
- Force an `lrclk` toggle after 10 bits of a left word → one `frame_err` pulse; `left_data` keeps its prior value; the following right word has no `valid`; the next frame recovers normally.
- Assert `rst` for 1 `mclk` mid-word → outputs read 0 asynchronously; FSM resyncs; capture resumes correctly two boundaries later.
- Sweep 7 words {50321, 2131, 34245, 12312, 9044432, 0, 16777215} alternating L/R → each appears bit-exact in the matching output register.
